// File: rtl/debug_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// debug_ctrl_pkg
// Shared definitions for the host-side debug controller: command byte codes,
// controller state encoding and the layout of the dump frame.
// -----------------------------------------------------------------------------
package debug_ctrl_pkg;

  // Command bytes accepted from the UART RX side (only while IDLE)
  localparam logic [7:0] CMD_RUN  = 8'h01;
  localparam logic [7:0] CMD_STEP = 8'h02;
  localparam logic [7:0] CMD_DUMP = 8'h03;

  // Dump frame layout: PC, cycle counter, then the GPRs in index order
  localparam int DUMP_WORDS = 34;
  localparam int WORD_PC    = 0;
  localparam int WORD_CNT   = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    DUMP_RD = 3'd3,
    DUMP_LD = 3'd4,
    DUMP_TX = 3'd5
  } state_t;

endpackage

// File: rtl/debug_ctrl_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Loads one word and emits it MSB byte first over a valid/ready byte stream.
// Once o_tx_valid is high, o_tx_data is held until the sink accepts it.
//
// Ports:
//   i_clock     system clock
//   i_reset     asynchronous, active-low reset
//   i_load      load i_word and start emitting (only issued while idle)
//   i_word      word to serialise
//   i_tx_ready  sink ready
//   o_tx_data   current byte (top byte of the shift register)
//   o_tx_valid  o_tx_data valid
//   o_done      one-cycle pulse coincident with the handshake of the last byte
// -----------------------------------------------------------------------------
module word_serializer #(
  parameter int NB_WORD = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_WORD-1:0] i_word,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_done
);

  localparam int N_BYTES = NB_WORD / NB_BYTE;
  localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

  logic [NB_WORD-1:0] r_shift;
  logic [NB_IDX-1:0]  r_byte_idx;
  logic               r_valid;
  logic               w_fire;
  logic               w_last;

  assign w_fire = r_valid & i_tx_ready;
  assign w_last = (r_byte_idx == LAST_IDX);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_shift    <= i_word;
      r_byte_idx <= '0;
      r_valid    <= 1'b1;
    end else if (w_fire) begin
      // Shifting in zeros leaves o_tx_data at 0 once the word is drained
      r_shift    <= r_shift << NB_BYTE;
      r_byte_idx <= r_byte_idx + 1'b1;
      if (w_last) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_tx_data  = r_shift[NB_WORD-1 -: NB_BYTE];
  assign o_tx_valid = r_valid;
  assign o_done     = w_fire & w_last;

endmodule

// File: rtl/debug_ctrl.sv
// -----------------------------------------------------------------------------
// debug_ctrl
// Host-side control/observation for the pipeline. Accepts RUN/STEP/DUMP
// command bytes, drives the pipeline valid input, counts valid cycles and
// dumps PC, the cycle counter and all GPRs as a 136-byte frame.
//
// Ports:
//   i_clock, i_reset        clock, asynchronous active-low reset
//   i_cmd_data/i_cmd_valid  command byte stream (RX side)
//   i_halt                  pipeline has retired HALT (level, sticky)
//   i_pc                    current pipeline PC
//   o_rf_addr/i_rf_data     register-file debug read port (1-cycle latency)
//   o_pipe_valid            pipeline i_valid
//   o_tx_data/o_tx_valid/i_tx_ready  byte stream to the TX side
//   o_busy                  controller not in IDLE
// -----------------------------------------------------------------------------
module debug_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int NB_REG        = 32,
  parameter int NB_REG_ADDR   = 5,
  parameter int REGFILE_DEPTH = 32,
  parameter int NB_BYTE       = 8,
  parameter int NB_WORD_IDX   = 6
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_BYTE-1:0]     i_cmd_data,
  input  logic                   i_cmd_valid,
  input  logic                   i_halt,
  input  logic [NB_REG-1:0]      i_pc,
  output logic [NB_REG_ADDR-1:0] o_rf_addr,
  input  logic [NB_REG-1:0]      i_rf_data,
  output logic                   o_pipe_valid,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy
);

  localparam logic [NB_WORD_IDX-1:0] IDX_PC   = NB_WORD_IDX'(WORD_PC);
  localparam logic [NB_WORD_IDX-1:0] IDX_CNT  = NB_WORD_IDX'(WORD_CNT);
  localparam logic [NB_WORD_IDX-1:0] IDX_GPR0 = NB_WORD_IDX'(WORD_CNT + 1);
  localparam logic [NB_WORD_IDX-1:0] IDX_LAST = NB_WORD_IDX'(REGFILE_DEPTH + 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_pipe_valid;
  logic                    w_pipe_valid_next;
  logic [NB_REG-1:0]       r_cnt;
  logic [NB_WORD_IDX-1:0]  r_word_idx;
  logic [NB_WORD_IDX-1:0]  w_word_idx_next;
  logic [NB_REG_ADDR-1:0]  r_rf_addr;
  logic                    w_load;
  logic [NB_REG-1:0]       w_word;
  logic                    w_ser_done;

  // GPR read address for a frame word; words before the GPRs read address 0
  function automatic logic [NB_REG_ADDR-1:0] f_rf_addr(input logic [NB_WORD_IDX-1:0] idx);
    logic [NB_WORD_IDX-1:0] off;
    off = idx - IDX_GPR0;
    f_rf_addr = (idx < IDX_GPR0) ? '0 : off[NB_REG_ADDR-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_pipe_valid <= 1'b0;
      r_cnt        <= '0;
      r_word_idx   <= '0;
      r_rf_addr    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pipe_valid <= w_pipe_valid_next;
      r_cnt        <= r_cnt + {{(NB_REG-1){1'b0}}, r_pipe_valid};
      r_word_idx   <= w_word_idx_next;
      // Address is registered from the next word index so it is already
      // presented during DUMP_RD; read data then arrives in DUMP_LD.
      r_rf_addr    <= f_rf_addr(w_word_idx_next);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_pipe_valid_next = 1'b0;
    w_word_idx_next   = r_word_idx;
    w_load            = 1'b0;
    case (r_state)
      IDLE: begin
        w_word_idx_next = '0;
        if (i_cmd_valid) begin
          case (i_cmd_data)
            CMD_RUN: begin
              if (i_halt) begin
                w_state_next = DUMP_RD;
              end else begin
                w_state_next      = RUN;
                w_pipe_valid_next = 1'b1;
              end
            end
            CMD_STEP: begin
              if (i_halt) begin
                w_state_next = DUMP_RD;
              end else begin
                w_state_next      = STEP;
                w_pipe_valid_next = 1'b1;
              end
            end
            CMD_DUMP: w_state_next = DUMP_RD;
            default:  w_state_next = IDLE;
          endcase
        end
      end
      RUN: begin
        if (i_halt) begin
          w_state_next = DUMP_RD;
        end else begin
          w_pipe_valid_next = 1'b1;
        end
      end
      // The single valid cycle is the one spent in STEP
      STEP:    w_state_next = DUMP_RD;
      DUMP_RD: w_state_next = DUMP_LD;
      DUMP_LD: begin
        w_load       = 1'b1;
        w_state_next = DUMP_TX;
      end
      DUMP_TX: begin
        if (w_ser_done) begin
          if (r_word_idx == IDX_LAST) begin
            w_state_next    = IDLE;
            w_word_idx_next = '0;
          end else begin
            w_state_next    = DUMP_RD;
            w_word_idx_next = r_word_idx + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Word captured into the serializer at DUMP_LD
  always_comb begin
    w_word = i_rf_data;
    if (r_word_idx == IDX_PC) begin
      w_word = i_pc;
    end else if (r_word_idx == IDX_CNT) begin
      w_word = r_cnt;
    end
  end

  word_serializer #(
    .NB_WORD (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_word     (w_word),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_done     (w_ser_done)
  );

  assign o_pipe_valid = r_pipe_valid;
  assign o_rf_addr    = r_rf_addr;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debug_ctrl
// Scoreboard bench: every command that should produce a frame pushes the
// expected 136 bytes (built from a simple model of PC, cycle count and GPR
// contents) into a queue; a monitor pops and compares on each TX handshake.
// -----------------------------------------------------------------------------
module tb_debug_ctrl;

  logic        i_clock;
  logic        i_reset;
  logic [7:0]  i_cmd_data;
  logic        i_cmd_valid;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [4:0]  o_rf_addr;
  logic [31:0] i_rf_data;
  logic        o_pipe_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;

  debug_ctrl dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_cmd_data   (i_cmd_data),
    .i_cmd_valid  (i_cmd_valid),
    .i_halt       (i_halt),
    .i_pc         (i_pc),
    .o_rf_addr    (o_rf_addr),
    .i_rf_data    (i_rf_data),
    .o_pipe_valid (o_pipe_valid),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rf_mem[32];
  logic [31:0] cnt_model;
  int          pv_total   = 0;
  int          pv_run     = 0;
  int          halt_after = 0;
  bit          stub_armed = 1'b0;
  bit          ready_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Expected frame: PC, cycle count, GPR0..31, each MSB byte first
  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
  endtask

  task automatic push_frame();
    push_word(i_pc);
    push_word(cnt_model);
    for (int r = 0; r < 32; r++) push_word(rf_mem[r]);
    $display("expect frame: pc=%h cnt=%h", i_pc, cnt_model);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge i_clock);
    i_cmd_data  = c;
    i_cmd_valid = 1'b1;
    @(negedge i_clock);
    i_cmd_valid = 1'b0;
    $display("cmd %h sent", c);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while ((o_busy || exp_q.size() != 0) && n < 4000);
    chk({name, "_idle"}, {31'd0, o_busy}, 32'd0);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_pipe_valid"}, {31'd0, o_pipe_valid}, 32'd0);
    chk({name, "_tx_valid"},   {31'd0, o_tx_valid},   32'd0);
    chk({name, "_tx_data"},    {24'd0, o_tx_data},    32'd0);
    chk({name, "_rf_addr"},    {27'd0, o_rf_addr},    32'd0);
    chk({name, "_busy"},       {31'd0, o_busy},       32'd0);
  endtask

  // Register file stub: read data follows the address within the cycle
  initial begin
    i_rf_data = '0;
    forever begin
      @(negedge i_clock);
      i_rf_data = rf_mem[o_rf_addr];
    end
  end

  // Pipeline stub: counts valid cycles; raises HALT after halt_after of them
  initial begin
    forever begin
      @(negedge i_clock);
      if (i_reset && o_pipe_valid) begin
        pv_total++;
        if (stub_armed) begin
          pv_run++;
          if (pv_run == halt_after) i_halt = 1'b1;
        end
      end
    end
  end

  // TX monitor: drives ready, checks hold rule and scoreboard bytes
  initial begin
    logic       hold_prev;
    logic [7:0] prev_data;
    logic [7:0] e;
    bit         end_chk;
    int         byte_no;
    hold_prev  = 1'b0;
    prev_data  = '0;
    end_chk    = 1'b0;
    byte_no    = 0;
    i_tx_ready = 1'b1;
    forever begin
      @(negedge i_clock);
      if (i_reset && hold_prev) begin
        chk("tx_hold_valid", {31'd0, o_tx_valid}, 32'd1);
        chk("tx_hold_data", {24'd0, o_tx_data}, {24'd0, prev_data});
      end
      if (end_chk) begin
        chk("busy_after_last", {30'd0, o_busy, o_tx_valid}, 32'd0);
        end_chk = 1'b0;
      end
      i_tx_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      hold_prev  = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
      if (i_reset && o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("tx_byte%0d", byte_no), {24'd0, o_tx_data}, {24'd0, e});
          byte_no++;
          if (byte_no == 136) begin
            byte_no = 0;
            end_chk = 1'b1;
            $display("frame complete");
          end
        end
      end
    end
  end

  initial begin
    int base;
    i_reset     = 1'b0;
    i_cmd_data  = '0;
    i_cmd_valid = 1'b0;
    i_halt      = 1'b0;
    i_pc        = '0;
    cnt_model   = '0;
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h1000 + r;
    repeat (3) @(negedge i_clock);
    check_reset_outputs("reset");
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);

    // Unknown code in IDLE
    base = pv_total;
    send_cmd(8'h7F);
    repeat (5) @(negedge i_clock);
    chk("bad_cmd_busy", {31'd0, o_busy}, 32'd0);
    chk("bad_cmd_pv", pv_total - base, 0);

    // RUN, HALT after 10 valid cycles
    i_pc       = $urandom;
    halt_after = 10;
    pv_run     = 0;
    stub_armed = 1'b1;
    cnt_model  = cnt_model + 10;
    push_frame();
    base = pv_total;
    send_cmd(8'h01);
    wait_idle("run10");
    chk("run10_pv", pv_total - base, 10);
    stub_armed = 1'b0;
    i_halt     = 1'b0;

    // RUN aborted by reset
    halt_after = 1000000;
    pv_run     = 0;
    stub_armed = 1'b1;
    send_cmd(8'h01);
    repeat (20) @(negedge i_clock);
    chk("midrun_pv", {31'd0, o_pipe_valid}, 32'd1);
    #2 i_reset = 1'b0;
    #20 check_reset_outputs("async_reset");
    #38 i_reset = 1'b1;
    stub_armed = 1'b0;
    cnt_model  = '0;

    // STEP x3, each followed by DUMP
    for (int k = 1; k <= 3; k++) begin
      i_pc      = $urandom;
      cnt_model = cnt_model + 1;
      push_frame();
      base = pv_total;
      send_cmd(8'h02);
      wait_idle("step");
      chk("step_pv", pv_total - base, 1);
      push_frame();
      base = pv_total;
      send_cmd(8'h03);
      wait_idle("dump");
      chk("dump_pv", pv_total - base, 0);
    end

    // STEP and RUN while halted: dump only
    i_halt = 1'b1;
    push_frame();
    base = pv_total;
    send_cmd(8'h02);
    wait_idle("step_halted");
    push_frame();
    send_cmd(8'h01);
    wait_idle("run_halted");
    chk("halted_pv", pv_total - base, 0);
    i_halt = 1'b0;

    // Random GPRs, random ready, commands during the dump ignored
    for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
    i_pc       = $urandom;
    ready_mode = 1'b1;
    push_frame();
    base = pv_total;
    send_cmd(8'h03);
    repeat (30) @(negedge i_clock);
    send_cmd(8'h01);
    send_cmd(8'h7F);
    send_cmd(8'h02);
    wait_idle("rand_ready");
    chk("dump_cmds_ignored_pv", pv_total - base, 0);
    ready_mode = 1'b0;
    push_frame();
    send_cmd(8'h03);
    wait_idle("ready_one");

    // Counter wrap
    @(negedge i_clock);
    force dut.r_cnt = 32'hFFFF_FFFE;
    @(negedge i_clock);
    release dut.r_cnt;
    cnt_model = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      cnt_model = cnt_model + 1;
      push_frame();
      send_cmd(8'h02);
      wait_idle("wrap_step");
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
